// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants for the four-digit seven-segment scan controller.
// Holds the segment patterns (active-low, bit 6 = a .. bit 0 = g), the blank
// pattern, the scan FSM state encoding and the leading-zero helper.
package display_scan_ctrl_pkg;

   typedef enum logic {
      GUARD_S = 1'b0,   // anodes off while the segment lines settle
      DRIVE_S = 1'b1    // selected digit anode enabled
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_ERR   = 7'b1001000;   // shown for codes 10..15

   localparam logic [6:0] SEG_0 = 7'b0000001;
   localparam logic [6:0] SEG_1 = 7'b1001111;
   localparam logic [6:0] SEG_2 = 7'b0010010;
   localparam logic [6:0] SEG_3 = 7'b0000110;
   localparam logic [6:0] SEG_4 = 7'b1001100;
   localparam logic [6:0] SEG_5 = 7'b0100100;
   localparam logic [6:0] SEG_6 = 7'b1100000;
   localparam logic [6:0] SEG_7 = 7'b0001111;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0001100;

   // A digit is a leading zero when it and every digit above it are zero.
   // Digit 0 is always shown so a value of zero still displays "0".
   function automatic logic lz_suppress(input logic [15:0] i_dat, input logic [1:0] i_idx);
      logic w_blank;
      w_blank = 1'b0;
      case (i_idx)
         2'd1:    w_blank = (i_dat[15:4]  == 12'd0);
         2'd2:    w_blank = (i_dat[15:8]  == 8'd0);
         2'd3:    w_blank = (i_dat[15:12] == 4'd0);
         default: w_blank = 1'b0;
      endcase
      return w_blank;
   endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Ports: i_digit (4-bit code in), o_seg (7-bit pattern out, bit 6 = a).
// Latency: none (pure combinational); no flow control.
module bcd_to_7seg
   import display_scan_ctrl_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_ERR;
      case (i_digit)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_ERR;
      endcase
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a four-digit common-anode display.
// Ports: clk, reset (async, active-high); load/data_in/dp_in/blank_lz capture
//        a new value into a shadow register, pending flags it until the frame
//        boundary; an/seg/dp are registered active-low display drives.
// Latency: an/seg/dp lag the slot counter by one cycle; a load shows up from
// the next frame boundary. Loads are always accepted (last load wins).
module display_scan_ctrl
   import display_scan_ctrl_pkg::*;
#(
   parameter int DIV   = 50000,   // cycles per digit slot
   parameter int GUARD = 2        // blanked cycles at the start of each slot
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] data_in,
   input  logic [3:0]  dp_in,
   input  logic        blank_lz,
   output logic        pending,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam logic [15:0] CNT_LAST = 16'(DIV - 1);
   localparam logic [15:0] GUARD_W  = 16'(GUARD);

   // scan position
   logic [15:0] r_cnt;
   logic [1:0]  r_idx;
   state_t      r_state;
   state_t      w_state_nxt;

   // shadow (written by load) and active (displayed) copies of the value
   logic [15:0] r_sh_dat;
   logic [3:0]  r_sh_dp;
   logic        r_sh_blz;
   logic [15:0] r_act_dat;
   logic [3:0]  r_act_dp;
   logic        r_act_blz;
   logic        r_pending;

   // registered display drives
   logic [3:0]  r_an;
   logic [6:0]  r_seg;
   logic        r_dp;

   logic        w_slot_end;
   logic        w_frame_end;
   logic [15:0] w_cnt_nxt;
   logic [3:0]  w_digit;
   logic [6:0]  w_dec_seg;
   logic [3:0]  w_an_nxt;
   logic [6:0]  w_seg_nxt;
   logic        w_dp_nxt;

   assign w_slot_end  = (r_cnt == CNT_LAST);
   assign w_frame_end = w_slot_end && (r_idx == 2'd3);
   assign w_cnt_nxt   = w_slot_end ? 16'd0 : r_cnt + 16'd1;
   assign w_digit     = r_act_dat[{r_idx, 2'b00} +: 4];

   bcd_to_7seg u_dec (
      .i_digit (w_digit),
      .o_seg   (w_dec_seg)
   );

   // slot counter and digit index
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= 16'd0;
         r_idx <= 2'd0;
      end else begin
         r_cnt <= w_cnt_nxt;
         if (w_slot_end) begin
            r_idx <= r_idx + 2'd1;
         end
      end
   end

   // FSM state register; the state always tracks the current counter value
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= GUARD_S;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next state plus the display drives for the current slot position
   always_comb begin
      w_state_nxt = r_state;
      w_an_nxt    = 4'b1111;
      w_seg_nxt   = SEG_BLANK;
      w_dp_nxt    = 1'b1;

      if (w_cnt_nxt < GUARD_W) begin
         w_state_nxt = GUARD_S;
      end else begin
         w_state_nxt = DRIVE_S;
      end

      case (r_state)
         DRIVE_S: begin
            w_an_nxt = ~(4'b0001 << r_idx);
            if (r_act_blz && lz_suppress(r_act_dat, r_idx)) begin
               w_seg_nxt = SEG_BLANK;
            end else begin
               w_seg_nxt = w_dec_seg;
            end
            // the decimal point survives leading-zero suppression
            w_dp_nxt = ~r_act_dp[r_idx];
         end
         default: begin
            w_an_nxt  = 4'b1111;
            w_seg_nxt = SEG_BLANK;
            w_dp_nxt  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_an  <= 4'b1111;
         r_seg <= SEG_BLANK;
         r_dp  <= 1'b1;
      end else begin
         r_an  <= w_an_nxt;
         r_seg <= w_seg_nxt;
         r_dp  <= w_dp_nxt;
      end
   end

   // Shadow/active double buffer. The transfer reads the pre-load shadow, so a
   // load on the boundary cycle is kept for the following frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sh_dat  <= 16'd0;
         r_sh_dp   <= 4'd0;
         r_sh_blz  <= 1'b0;
         r_act_dat <= 16'd0;
         r_act_dp  <= 4'd0;
         r_act_blz <= 1'b0;
         r_pending <= 1'b0;
      end else begin
         if (w_frame_end) begin
            r_act_dat <= r_sh_dat;
            r_act_dp  <= r_sh_dp;
            r_act_blz <= r_sh_blz;
         end
         if (load) begin
            r_sh_dat <= data_in;
            r_sh_dp  <= dp_in;
            r_sh_blz <= blank_lz;
         end
         if (load) begin
            r_pending <= 1'b1;
         end else if (w_frame_end) begin
            r_pending <= 1'b0;
         end
      end
   end

   assign pending = r_pending;
   assign an      = r_an;
   assign seg     = r_seg;
   assign dp      = r_dp;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (DIV=8, GUARD=2).
// A behavioural model tracks absolute time since reset and derives slot,
// digit and frame boundaries arithmetically; every cycle is compared.
module tb_display_scan_ctrl;

   localparam int DIV   = 8;
   localparam int GUARD = 2;
   localparam int FRAME = 4 * DIV;

   logic        clk;
   logic        reset;
   logic        load;
   logic [15:0] data_in;
   logic [3:0]  dp_in;
   logic        blank_lz;
   logic        pending;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   display_scan_ctrl #(.DIV(DIV), .GUARD(GUARD)) dut (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .data_in  (data_in),
      .dp_in    (dp_in),
      .blank_lz (blank_lz),
      .pending  (pending),
      .an       (an),
      .seg      (seg),
      .dp       (dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // model state
   int          pos;        // cycles since reset release, before the next edge
   logic [15:0] m_act, m_sh;
   logic [3:0]  m_act_dp, m_sh_dp;
   logic        m_act_blz, m_sh_blz, m_pend;
   logic [6:0]  seg_tab [16];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      pos       = 0;
      m_act     = 16'd0;
      m_sh      = 16'd0;
      m_act_dp  = 4'd0;
      m_sh_dp   = 4'd0;
      m_act_blz = 1'b0;
      m_sh_blz  = 1'b0;
      m_pend    = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_an"},  32'(an),      32'hF);
      check({tag, "_seg"}, 32'(seg),     32'h7F);
      check({tag, "_dp"},  32'(dp),      32'h1);
      check({tag, "_pnd"}, 32'(pending), 32'h0);
   endtask

   // One clock: apply inputs, advance the model across the edge, check #1 later.
   task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] p, input logic b);
      int          c, ix;
      logic [3:0]  e_an;
      logic [6:0]  e_seg;
      logic        e_dp;
      logic [15:0] upper;
      logic        fe;
      load     = ld;
      data_in  = d;
      dp_in    = p;
      blank_lz = b;
      @(posedge clk);
      c  = pos % DIV;
      ix = (pos / DIV) % 4;
      if (c < GUARD) begin
         e_an  = 4'hF;
         e_seg = 7'h7F;
         e_dp  = 1'b1;
      end else begin
         e_an  = 4'(15 - (1 << ix));
         upper = m_act >> (4 * ix);
         if (m_act_blz && ix > 0 && upper == 16'd0) e_seg = 7'h7F;
         else                                       e_seg = seg_tab[upper[3:0]];
         e_dp = ~m_act_dp[ix];
      end
      fe = ((pos % FRAME) == FRAME - 1);
      if (fe) begin
         m_act     = m_sh;
         m_act_dp  = m_sh_dp;
         m_act_blz = m_sh_blz;
      end
      if (ld) begin
         m_sh     = d;
         m_sh_dp  = p;
         m_sh_blz = b;
         m_pend   = 1'b1;
      end else if (fe) begin
         m_pend = 1'b0;
      end
      pos++;
      #1;
      check("an",      32'(an),      32'(e_an));
      check("seg",     32'(seg),     32'(e_seg));
      check("dp",      32'(dp),      32'(e_dp));
      check("pending", 32'(pending), 32'(m_pend));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, data_in, dp_in, blank_lz);
   endtask

   task automatic idle_until(input int phase);
      while ((pos % FRAME) != phase) step(1'b0, data_in, dp_in, blank_lz);
   endtask

   function automatic logic [15:0] rnd_data();
      logic [15:0] v;
      for (int k = 0; k < 4; k++)
         v[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      return v;
   endfunction

   initial begin
      seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111;
      seg_tab[2]  = 7'b0010010; seg_tab[3]  = 7'b0000110;
      seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
      seg_tab[6]  = 7'b1100000; seg_tab[7]  = 7'b0001111;
      seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0001100;
      for (int k = 10; k < 16; k++) seg_tab[k] = 7'b1001000;

      reset    = 1'b1;
      load     = 1'b0;
      data_in  = 16'd0;
      dp_in    = 4'd0;
      blank_lz = 1'b0;
      model_reset();
      #1;
      check_idle("rst");
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;

      // reset release: digit 0 guard for 2 cycles, drive for 6, then digit 1 guard
      for (int i = 0; i < DIV; i++) begin
         step(1'b0, 16'd0, 4'd0, 1'b0);
         check("rel_an", 32'(an), (i < GUARD) ? 32'hF : 32'hE);
      end
      step(1'b0, 16'd0, 4'd0, 1'b0);
      check("rel_d1_guard", 32'(an), 32'hF);

      // 0x1234 with dp on digit 2
      step(1'b1, 16'h1234, 4'b0100, 1'b0);
      idle(2 * FRAME);

      // leading-zero suppression
      step(1'b1, 16'h0070, 4'b0000, 1'b1);
      idle(2 * FRAME);

      // non-BCD code, suppression off, dp on a zero digit
      step(1'b1, 16'h000A, 4'b1000, 1'b0);
      idle(2 * FRAME);

      // two loads in one frame: last wins
      idle_until(3);
      step(1'b1, 16'h1111, 4'b0001, 1'b0);
      idle(3);
      step(1'b1, 16'h2222, 4'b0010, 1'b0);
      idle(2 * FRAME);

      // load exactly on the frame-boundary cycle
      idle_until(5);
      step(1'b1, 16'h5555, 4'b0011, 1'b0);
      idle_until(FRAME - 1);
      step(1'b1, 16'h6666, 4'b1100, 1'b1);
      check("bnd_pending", 32'(pending), 32'h1);
      idle(2 * FRAME);

      // suppressed digits still light dp
      step(1'b1, 16'h0005, 4'b1110, 1'b1);
      idle(2 * FRAME);

      // reset mid-frame with a value pending
      idle_until(12);
      step(1'b1, 16'h9999, 4'b1111, 1'b0);
      idle(3);
      #2 reset = 1'b1;
      #1;
      check_idle("mid_rst");
      @(posedge clk);
      #1;
      check_idle("mid_rst_hold");
      #1 reset = 1'b0;
      model_reset();
      idle(2 * FRAME);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 11) == 0)
            step(1'b1, rnd_data(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         else
            step(1'b0, data_in, dp_in, blank_lz);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
